seven_segment_scanner: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode 7-segment display. It is the downstream stage of the seven-segment encoder: it consumes the flattened 28-bit active-low segment word and scans one digit at a time onto the shared cathode bus. Per-digit ghosting guard, 8-level brightness PWM, and frame-synchronous input latching are included so the display never shows a torn word.

---
 rtl/seven_segment_scanner.sv | 109 ++++++++++
 tb/tb_seven_segment_scanner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with
// per-slot ghosting guard, 8-level brightness PWM and frame-synchronous input latching.
module seven_segment_scanner #(
   parameter int unsigned TICKS_PER_DIGIT = 100000,
   parameter int unsigned BLANK_TICKS     = 2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] seg_data_flat,
   input  logic        enable,
   input  logic [2:0]  brightness,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_start
);

   localparam int unsigned CW      = $clog2(TICKS_PER_DIGIT);
   localparam int unsigned ON_SPAN = TICKS_PER_DIGIT - BLANK_TICKS;

   // Slot count at which the drive phase ends, one entry per brightness level
   localparam int unsigned ON_END [8] = '{
      BLANK_TICKS + (ON_SPAN * 1) / 8,
      BLANK_TICKS + (ON_SPAN * 2) / 8,
      BLANK_TICKS + (ON_SPAN * 3) / 8,
      BLANK_TICKS + (ON_SPAN * 4) / 8,
      BLANK_TICKS + (ON_SPAN * 5) / 8,
      BLANK_TICKS + (ON_SPAN * 6) / 8,
      BLANK_TICKS + (ON_SPAN * 7) / 8,
      BLANK_TICKS + ON_SPAN
   };

   typedef enum logic [1:0] {IDLE, GUARD, DRIVE, DARK} state_t;

   localparam state_t SLOT_FIRST = (BLANK_TICKS == 0) ? DRIVE : GUARD;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [1:0]             idx_q, idx_d;
   logic [2:0]             bright_q, bright_d;
   logic [3:0][6:0]        shadow_q, shadow_d;
   logic [3:0]             an_d;
   logic [6:0]             seg_d;
   logic                   fs_d;

   // State register; outputs are registered from the next-cycle decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         bright_q    <= '0;
         shadow_q    <= '1;
         an          <= 4'hF;
         seg         <= 7'h7F;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         bright_q    <= bright_d;
         shadow_q    <= shadow_d;
         an          <= an_d;
         seg         <= seg_d;
         frame_start <= fs_d;
      end
   end

   // Next-state: enable drop dominates any slot wrap
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bright_d = bright_q;
      shadow_d = shadow_q;
      fs_d     = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (state_q == IDLE || cnt_q == CW'(TICKS_PER_DIGIT - 1)) begin
         state_d  = SLOT_FIRST;
         cnt_d    = '0;
         idx_d    = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;
         bright_d = brightness;
         if (idx_d == 2'd0) begin
            shadow_d = seg_data_flat;
            fs_d     = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
         case (state_q)
            GUARD:   if (32'(cnt_d) == BLANK_TICKS)      state_d = DRIVE;
            DRIVE:   if (32'(cnt_d) == ON_END[bright_q]) state_d = DARK;
            default: ;
         endcase
      end
   end

   // Output decode of the upcoming cycle
   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      if (state_d == DRIVE) begin
         an_d[idx_d] = 1'b0;
         seg_d       = shadow_d[idx_d];
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed and randomized-invariant bench for seven_segment_scanner
// (TICKS_PER_DIGIT=16, BLANK_TICKS=2).
module tb_seven_segment_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [27:0] seg_data_flat;
   logic        enable;
   logic [2:0]  brightness;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_start;

   int n_cmp = 0;
   int n_bad = 0;

   // floor(14*(b+1)/8) computed by hand
   int on_tab [8] = '{1, 3, 5, 7, 8, 10, 12, 14};
   int fb [4][4]  = '{'{7, 7, 7, 7}, '{7, 7, 7, 7}, '{3, 0, 0, 0}, '{0, 0, 0, 0}};

   logic [3:0][6:0] stop_w;
   logic [3:0][6:0] dash_w;

   seven_segment_scanner #(.TICKS_PER_DIGIT(16), .BLANK_TICKS(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .seg_data_flat (seg_data_flat),
      .enable        (enable),
      .brightness    (brightness),
      .an            (an),
      .seg           (seg),
      .frame_start   (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] ea;
      logic [6:0] es;
      logic [3:0][6:0] w;
      logic drv, en_prev, active;
      int slot, k, b, pos;

      stop_w = {~7'h6D, ~7'h78, ~7'h3F, ~7'h73};
      dash_w = {4{~7'h40}};

      // Reset held with enable high
      rst_n = 1'b0; enable = 1'b1; brightness = 3'd7; seg_data_flat = stop_w;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_an", 32'(an), 32'hF);
         check("rst_seg", 32'(seg), 32'h7F);
         check("rst_fs", 32'(frame_start), 32'h0);
      end
      rst_n = 1'b1;
      step();

      // Four frames: full scan, mid-frame data change, brightness changes
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < 64; c++) begin
            slot = c / 16;
            k    = c % 16;
            b    = fb[f][slot];
            w    = (f == 0) ? stop_w : dash_w;
            drv  = (k >= 2) && (k < 2 + on_tab[b]);
            ea   = 4'hF;
            es   = 7'h7F;
            if (drv) begin
               ea[slot] = 1'b0;
               es       = w[slot];
            end
            check($sformatf("fs f%0d c%0d", f, c), 32'(frame_start), 32'(c == 0));
            check($sformatf("an f%0d c%0d", f, c), 32'(an), 32'(ea));
            check($sformatf("seg f%0d c%0d", f, c), 32'(seg), 32'(es));
            if (f == 0 && c == 20) seg_data_flat = dash_w;
            if (f == 1 && c == 63) brightness = 3'd3;
            if (f == 2 && c == 5)  brightness = 3'd0;
            if (f == 3 && c == 63) brightness = 3'd7;
            step();
         end
      end

      // Enable drop at cnt=5 of digit 2
      repeat (37) step();
      check("en_pre_an", 32'(an), 32'hB);
      check("en_pre_seg", 32'(seg), 32'h3F);
      enable = 1'b0;
      step();
      check("en_off_an", 32'(an), 32'hF);
      check("en_off_seg", 32'(seg), 32'h7F);
      check("en_off_fs", 32'(frame_start), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("en_dark_an", 32'(an), 32'hF);
         check("en_dark_fs", 32'(frame_start), 32'h0);
      end
      seg_data_flat = stop_w;
      enable = 1'b1;
      step();
      check("re_fs", 32'(frame_start), 32'h1);
      check("re_an0", 32'(an), 32'hF);
      step();
      check("re_fs1", 32'(frame_start), 32'h0);
      check("re_an1", 32'(an), 32'hF);
      step();
      check("re_an2", 32'(an), 32'hE);
      check("re_seg2", 32'(seg), 32'h0C);

      // Asynchronous reset during a drive cycle
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_an", 32'(an), 32'hF);
      check("arst_seg", 32'(seg), 32'h7F);
      check("arst_fs", 32'(frame_start), 32'h0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("arst_idle_an", 32'(an), 32'hF);

      // Randomized invariants against a slot-position model
      active = 1'b0;
      pos    = 0;
      for (int i = 0; i < 10000; i++) begin
         enable        = ($urandom_range(0, 99) < 97);
         brightness    = 3'($urandom_range(0, 7));
         seg_data_flat = 28'($urandom);
         en_prev       = enable;
         step();
         if (!en_prev) begin
            active = 1'b0;
         end else if (!active) begin
            active = 1'b1;
            pos    = 0;
         end else begin
            pos = (pos + 1) % 16;
         end
         check($sformatf("inv_onehot %0d", i), 32'($countones(~an) <= 1), 32'h1);
         if (!active || pos < 2)
            check($sformatf("inv_guard %0d", i), 32'(an), 32'hF);
         if (an == 4'hF)
            check($sformatf("inv_dark %0d", i), 32'(seg), 32'h7F);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
